// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, immediate
// formats, ALU operations, ALU decode classes and FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Turns the FSM's coarse ALU request plus funct3/funct7 into an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_t   alu_op,
    input  logic [2:0] funct3,
    input  logic      op5,
    input  logic      funct7b5,
    output alu_ctrl_t alu_control
);

    // Only R-type (op5=1) can select sub; addi with imm[10] set stays an add.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I main controller: state register, next-state logic,
// per-state datapath control decode and immediate-format decode.
module control_unit
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal
);

    state_t    state;
    alu_op_t   alu_op;
    alu_ctrl_t alu_ctrl;

    logic       pc_update;
    logic       branch;
    logic       adr_src_d;
    logic       mem_write_d;
    logic       ir_write_d;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic [1:0] alu_src_a_d;
    logic [1:0] alu_src_b_d;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl)
    );

    // Sequence the datapath; memory states stall on mem_ready, TRAP is terminal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD:   state <= S_MEMADR;
                        OP_STORE:  state <= S_MEMADR;
                        OP_RTYPE:  state <= S_EXECR;
                        OP_ITYPE:  state <= S_EXECI;
                        OP_BRANCH: state <= S_BRANCH;
                        OP_JAL:    state <= S_JAL;
                        OP_LUI:    state <= S_LUI;
                        default:   state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_LUI:      state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; everything not named in a state stays 0.
    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_op       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                ir_write_d   = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_d = 1'b1;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_d = 2'b10;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d = 2'b10;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_update   = 1'b1;
            end
            S_LUI: begin
                result_src_d = 2'b11;
                reg_write_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset forces every control low so an aborted instruction cannot fire a strobe.
    always_comb begin
        pc_write    = !reset && (pc_update || (branch && (zero ^ funct3[0])));
        adr_src     = !reset && adr_src_d;
        mem_write   = !reset && mem_write_d;
        ir_write    = !reset && ir_write_d;
        reg_write   = !reset && reg_write_d;
        illegal     = !reset && (state == S_TRAP);
        result_src  = reset ? 2'b00 : result_src_d;
        alu_src_a   = reset ? 2'b00 : alu_src_a_d;
        alu_src_b   = reset ? 2'b00 : alu_src_b_d;
        alu_control = reset ? 3'b000 : alu_ctrl;
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_LUI:    imm_src = IMM_U;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step drives inputs, queues the
// expected control word, and compares it mid-cycle.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    logic [17:0] expQ[$];
    string       tagQ[$];

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1110011;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .illegal     (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Packs an expected control word in port order.
    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [2:0] imm,
                                       input logic rw, input logic ill);
        return {pcw, adr, mw, irw, res, a, b, alu, imm, rw, ill};
    endfunction

    // Drives the instruction fields and handshake inputs and queues what the controller should show.
    task automatic applyStimulus(input string tag, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rdy,
                                 input logic [17:0] e);
        op        = o;
        funct3    = f3;
        funct7b5  = f7;
        zero      = z;
        mem_ready = rdy;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // Samples mid-cycle, compares with the queued expectation, then moves to just past the next edge.
    task automatic checkOutput();
        logic [17:0] e;
        logic [17:0] obs;
        string       t;
        #3;
        e   = expQ.pop_front();
        t   = tagQ.pop_front();
        obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, imm_src, reg_write, illegal};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy, input logic [17:0] e);
        applyStimulus(tag, o, f3, f7, z, rdy, e);
        checkOutput();
    endtask

    // Directed instruction sequence.
    initial begin
        reset = 1'b1;
        applyStimulus("init", LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        @(posedge clk);
        #1;
        step("reset_hold", LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        expQ.delete();
        tagQ.delete();
        reset = 1'b0;

        // lw, no wait states
        step("lw_fetch",   LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        step("lw_decode",  LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
        step("lw_memadr",  LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
        step("lw_memread", LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        step("lw_memwb",   LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,3'b000,1,0));

        // sw with one fetch wait and two write waits
        step("sw_fetch_wait", SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b001,0,0));
        step("sw_fetch",      SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b001,0,0));
        step("sw_decode",     SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b001,0,0));
        step("sw_memadr",     SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
        step("sw_write_w1",   SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b001,0,0));
        step("sw_write_w2",   SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b001,0,0));
        step("sw_write_done", SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b001,0,0));

        // sub (R-type)
        step("sub_fetch",  RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        step("sub_decode", RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
        step("sub_execr",  RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,0));
        step("sub_aluwb",  RT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));

        // addi with imm bit 30 set must stay add; ori decodes to or
        step("addi_fetch",  IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        step("addi_decode", IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
        step("addi_execi",  IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
        step("addi_aluwb",  IT, 3'b000, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));
        step("ori_fetch",   IT, 3'b110, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        step("ori_decode",  IT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
        step("ori_execi",   IT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b011,3'b000,0,0));
        step("ori_aluwb",   IT, 3'b110, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,0));

        // beq taken, bne not taken, both with zero=1
        step("beq_fetch",  BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b010,0,0));
        step("beq_decode", BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0,0));
        step("beq_branch", BR, 3'b000, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,0));
        step("bne_fetch",  BR, 3'b001, 1'b0, 1'b1, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b010,0,0));
        step("bne_decode", BR, 3'b001, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0,0));
        step("bne_branch", BR, 3'b001, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,0));

        // jal then lui
        step("jal_fetch",  JAL, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b100,0,0));
        step("jal_decode", JAL, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b100,0,0));
        step("jal_jal",    JAL, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b100,0,0));
        step("jal_aluwb",  JAL, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b100,1,0));
        step("lui_fetch",  LUI, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b011,0,0));
        step("lui_decode", LUI, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b011,0,0));
        step("lui_lui",    LUI, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b11,2'b00,2'b00,3'b000,3'b011,1,0));

        // sw aborted by reset while waiting in MEMWRITE
        step("sw2_fetch",  SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b001,0,0));
        step("sw2_decode", SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b001,0,0));
        step("sw2_memadr", SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0));
        step("sw2_write",  SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b001,0,0));
        reset = 1'b1;
        step("sw2_reset",  SW, 3'b010, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b001,0,0));
        reset = 1'b0;
        step("post_reset_fetch", SW, 3'b010, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b001,0,0));

        // unsupported opcode traps and stays trapped
        step("bad_fetch",  BAD, 3'b000, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
        step("bad_decode", BAD, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
        for (int i = 0; i < 10; i++) begin
            step($sformatf("trap_%0d", i), BAD, 3'b000, 1'b0, i[0], i[1],
                 mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,1));
        end
        reset = 1'b1;
        step("trap_reset", BAD, 3'b000, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        reset = 1'b0;
        step("trap_cleared", LW, 3'b010, 1'b0, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guards against the bench stalling.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
